// File: rtl/ram_display_controller.sv
// Button-driven RAM editor: edge-detected buttons step an address, store switch data or
// sweep-clear the RAM; the word at the current address is scanned onto hex 7-segment digits.
module ram_display_controller #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int DIGITS   = DATA_W / 4,
  parameter int WRAP     = 1,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              storeButton,
  input  logic              upButton,
  input  logic              downButton,
  input  logic              clearButton,
  input  logic [DATA_W-1:0] sw,
  output logic [ADDR_W-1:0] led,
  output logic [6:0]        SSD_LED_out,
  output logic [DIGITS-1:0] Anode_Activate,
  output logic              busy
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [ADDR_W-1:0]   r_clr_addr, w_clr_addr_next;
  logic [3:0]          r_btn_prev;
  logic                r_armed;
  logic [3:0]          w_btn, w_edge;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rdata;
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic [DIG_W-1:0]    r_digit;
  logic [3:0]          w_nibbles [DIGITS];
  logic [3:0]          w_nibble;

  // r_armed suppresses edges on the first cycle after reset so held buttons only seed history.
  assign w_btn  = {clearButton, downButton, upButton, storeButton};
  assign w_edge = r_armed ? (w_btn & ~r_btn_prev) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_prev <= 4'b0000;
      r_armed    <= 1'b0;
    end else begin
      r_btn_prev <= w_btn;
      r_armed    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_addr     <= w_addr_next;
      r_clr_addr <= w_clr_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_addr_next     = r_addr;
    w_clr_addr_next = r_clr_addr;
    w_we            = 1'b0;
    w_waddr         = r_addr;
    w_wdata         = sw;
    case (r_state)
      ST_IDLE: begin
        if (w_edge[3]) begin
          w_state_next    = ST_CLEAR;
          w_clr_addr_next = '0;
        end else begin
          w_we = w_edge[0];
          if (w_edge[1] && !w_edge[2]) begin
            if (r_addr == ADDR_MAX) w_addr_next = (WRAP != 0) ? '0 : r_addr;
            else                    w_addr_next = r_addr + ADDR_W'(1);
          end else if (w_edge[2] && !w_edge[1]) begin
            if (r_addr == '0) w_addr_next = (WRAP != 0) ? ADDR_MAX : r_addr;
            else              w_addr_next = r_addr - ADDR_W'(1);
          end
        end
      end
      ST_CLEAR: begin
        w_we            = 1'b1;
        w_waddr         = r_clr_addr;
        w_wdata         = '0;
        w_clr_addr_next = r_clr_addr + ADDR_W'(1);
        if (r_clr_addr == ADDR_MAX) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // RAM contents deliberately survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdata <= '0;
    else        r_rdata <= r_mem[r_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_digit    <= (r_digit == DIG_W'(DIGITS - 1)) ? '0 : r_digit + DIG_W'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_nibbles[gi]      = r_rdata[4*gi +: 4];
      assign Anode_Activate[gi] = (r_digit != DIG_W'(gi));
    end
  endgenerate

  assign w_nibble = w_nibbles[r_digit];

  always_comb begin
    SSD_LED_out = 7'b1111111;
    case (w_nibble)
      4'h0: SSD_LED_out = 7'b1000000;
      4'h1: SSD_LED_out = 7'b1111001;
      4'h2: SSD_LED_out = 7'b0100100;
      4'h3: SSD_LED_out = 7'b0110000;
      4'h4: SSD_LED_out = 7'b0011001;
      4'h5: SSD_LED_out = 7'b0010010;
      4'h6: SSD_LED_out = 7'b0000010;
      4'h7: SSD_LED_out = 7'b1111000;
      4'h8: SSD_LED_out = 7'b0000000;
      4'h9: SSD_LED_out = 7'b0010000;
      4'hA: SSD_LED_out = 7'b0001000;
      4'hB: SSD_LED_out = 7'b0000011;
      4'hC: SSD_LED_out = 7'b1000110;
      4'hD: SSD_LED_out = 7'b0100001;
      4'hE: SSD_LED_out = 7'b0000110;
      4'hF: SSD_LED_out = 7'b0001110;
      default: SSD_LED_out = 7'b1111111;
    endcase
  end

  assign led  = r_addr;
  assign busy = (r_state == ST_CLEAR);

endmodule

// File: doc/ram_display_controller.md
RAM_DISPLAY_CONTROLLER -- requirements
Module: ram_display_controller

Interface
REQ-001 SHALL provide parameter DATA_W, default 16: RAM word width, a multiple of 4.
REQ-002 SHALL provide parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL provide parameter DIGITS, default DATA_W/4: seven-segment digits driven.
REQ-004 SHALL provide parameter WRAP, default 1: 1 = address wraps at the ends, 0 = address saturates.
REQ-005 SHALL provide parameter SCAN_DIV, default 100000: clk cycles per digit refresh slot, minimum 2.
REQ-006 SHALL provide port clk, input, 1: single clock; all state on its rising edge.
REQ-007 SHALL provide port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL provide port storeButton, input, 1: debounced level; a rising edge requests a write.
REQ-009 SHALL provide port upButton, input, 1: debounced level; a rising edge requests address +1.
REQ-010 SHALL provide port downButton, input, 1: debounced level; a rising edge requests address -1.
REQ-011 SHALL provide port clearButton, input, 1: debounced level; a rising edge requests a clear of all RAM.
REQ-012 SHALL provide port sw, input, DATA_W: write data.
REQ-013 SHALL provide port led, output, ADDR_W: current address.
REQ-014 SHALL provide port SSD_LED_out, output, 7: segments {g..a}, active low.
REQ-015 SHALL provide port Anode_Activate, output, DIGITS: one-hot-low digit enable.
REQ-016 SHALL provide port busy, output, 1: high while a clear sweep is in progress.

Function
REQ-017 SHALL detect each button's rising edge with a registered previous value; one request per edge, held levels ignored.
REQ-018 SHALL contain a DEPTH x DATA_W RAM with synchronous write and registered read, 1-cycle read latency.
REQ-019 SHALL implement FSM states IDLE and CLEAR.
REQ-020 SHALL, in IDLE, on an up edge, increment addr; at DEPTH-1 go to 0 if WRAP=1, else hold.
REQ-021 SHALL, in IDLE, on a down edge, decrement addr; at 0 go to DEPTH-1 if WRAP=1, else hold.
REQ-022 SHALL, on simultaneous up and down edges, leave addr unchanged.
REQ-023 SHALL, in IDLE, on a store edge, write sw to RAM[addr] in that cycle, using addr before any same-cycle up/down update.
REQ-024 SHALL, in IDLE, on a clear edge, enter CLEAR: write 0 to addresses 0..DEPTH-1 on consecutive cycles, busy=1 for exactly DEPTH cycles, then return to IDLE.
REQ-025 SHALL give a clear edge priority over store/up/down edges in the same cycle, and discard those other edges.
REQ-026 SHALL ignore all store/up/down/clear edges while in CLEAR; addr SHALL be unchanged by a clear.
REQ-027 SHALL display rdata = RAM[addr], registered, updated 1 cycle after an addr change or a write to the current addr (read-after-write shows the new data).
REQ-028 SHALL scan digits with a SCAN_DIV counter; digit k (k=0 rightmost) shows rdata[4k+3:4k] as hex 0-F and is active during slot k, then k+1 mod DIGITS.
REQ-029 SHALL drive hex glyphs active low: 0=7'b1000000, 1=7'b1111001, ..., 8=7'b0000000, F=7'b0001110.
REQ-030 SHALL drive led = addr combinationally from the addr register.

Reset
REQ-031 SHALL, on rst_n low (asynchronous), set addr=0, FSM=IDLE, busy=0, button edge history=0, scan counter=0, digit index=0, rdata=0.
REQ-032 SHALL drive Anode_Activate = all-ones except bit 0 low, and SSD_LED_out = glyph of 0, during and after reset.
REQ-033 SHALL NOT alter RAM contents on reset; an abort mid-CLEAR leaves the remaining addresses unchanged.
REQ-034 SHALL register post-release button levels as history, so a button held through reset release produces no edge.

Verification
REQ-035 SHALL test write/read: sw=16'hBEEF, store edge at addr 0, up, sw=16'h1234, store, down -> rdata 16'hBEEF, 1 cycle after addr=0.
REQ-036 SHALL test wrap/saturate: WRAP=1, addr 15, up -> addr 0, down -> addr 15; WRAP=0, addr 15, up -> stays 15.
REQ-037 SHALL test clear: with data in RAM, a clear edge -> busy high 16 cycles, every address reads 0, then store/up accepted.
REQ-038 SHALL test simultaneous events: up+down same cycle -> addr unchanged; store+up at addr 3 -> RAM[3]=sw, addr=4.
REQ-039 SHALL test scan: SCAN_DIV=4, rdata=16'h12AF -> digits 0..3 show F,A,2,1, each 4 cycles, anode pattern 1110,1101,1011,0111.
REQ-040 SHALL test reset mid-CLEAR: assert rst_n low at sweep cycle 5 -> busy=0, addr=0, RAM[5..15] retain prior values.
